// File: rtl/node_packet_queue_pkg.sv
// Shared widths and TX handshake state encodings for the node packet queue.
package node_packet_queue_pkg;

    localparam int NODE_TX_PKT_W = 29;
    localparam int NODE_RX_PKT_W = 24;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_VALID = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/node_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
module node_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd, do_wr;

    // A pop in the same cycle frees the slot, so a write while full is accepted alongside it.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/node_packet_queue.sv
// Bidirectional packet buffering between the processor node and router_core.
module node_packet_queue
    import node_packet_queue_pkg::*;
#(
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                     Clk_R,
    input  logic                     Rst_n,
    input  logic [NODE_TX_PKT_W-1:0] Node_Tx_Pkt,
    input  logic                     Node_Tx_Wr,
    output logic                     Node_Tx_Full,
    output logic                     Node_Tx_Ovf,
    output logic [NODE_TX_PKT_W-1:0] Packet_From_Node,
    output logic                     Packet_From_Node_Valid,
    input  logic                     Core_Load_Ack,
    input  logic [NODE_RX_PKT_W-1:0] Packet_To_Node,
    input  logic                     Packet_To_Node_Valid,
    output logic [NODE_RX_PKT_W-1:0] Node_Rx_Pkt,
    output logic                     Node_Rx_Valid,
    input  logic                     Node_Rx_Rd,
    output logic [DROP_CNT_W-1:0]    Rx_Drop_Cnt
);

    tx_state_e                state_q, state_d;
    logic [NODE_TX_PKT_W-1:0] pkt_q, pkt_d;
    logic [NODE_TX_PKT_W-1:0] tx_rdata;
    logic                     tx_empty, tx_full, tx_wr, tx_rd;
    logic                     ovf_q;
    logic [DROP_CNT_W-1:0]    drop_q;
    logic                     rx_empty, rx_full, rx_drop;

    // TX writes are gated on the pre-edge Full, so a simultaneous pop never lets one through.
    assign tx_wr = Node_Tx_Wr && !tx_full;

    node_sync_fifo #(.WIDTH(NODE_TX_PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .wr    (tx_wr),
        .wdata (Node_Tx_Pkt),
        .rd    (tx_rd),
        .rdata (tx_rdata),
        .empty (tx_empty),
        .full  (tx_full)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        tx_rd   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    pkt_d   = tx_rdata;
                    state_d = TX_VALID;
                end
            end
            TX_VALID: begin
                if (Core_Load_Ack) begin
                    tx_rd   = 1'b1;
                    state_d = TX_GAP;
                end
            end
            TX_GAP:  state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge Clk_R) begin
        if (!Rst_n) begin
            state_q <= TX_IDLE;
            pkt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            if (Node_Tx_Wr && tx_full) ovf_q <= 1'b1;
        end
    end

    assign Packet_From_Node       = pkt_q;
    assign Packet_From_Node_Valid = (state_q == TX_VALID);
    assign Node_Tx_Full           = tx_full;
    assign Node_Tx_Ovf            = ovf_q;

    node_sync_fifo #(.WIDTH(NODE_RX_PKT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .wr    (Packet_To_Node_Valid),
        .wdata (Packet_To_Node),
        .rd    (Node_Rx_Rd),
        .rdata (Node_Rx_Pkt),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign rx_drop = Packet_To_Node_Valid && rx_full && !Node_Rx_Rd;

    always_ff @(posedge Clk_R) begin
        if (!Rst_n) begin
            drop_q <= '0;
        end else if (rx_drop && !(&drop_q)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign Node_Rx_Valid = !rx_empty;
    assign Rx_Drop_Cnt   = drop_q;

endmodule
